// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared ISA definitions for the single-cycle 16-bit CPU and its instruction
//   memory loader: instruction/opcode widths, opcode codes, register codes and
//   the loader FSM state encoding.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int ISA_DATA_W = 16;
  localparam int ISA_OP_W   = 5;

  // Opcode field = instr[ISA_DATA_W-1 -: ISA_OP_W]
  localparam logic [ISA_OP_W-1:0] OP_NOP  = 5'b00001;
  localparam logic [ISA_OP_W-1:0] OP_ADDI = 5'b10011;
  localparam logic [ISA_OP_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [2:0] {
    REG_S0, REG_S1, REG_S2, REG_S3, REG_S4, REG_S5, REG_S6, REG_S7
  } reg_code_e;

  // Loader FSM encoding, kept as plain constants so legacy tooling can
  // display and force state values directly.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_BOOT   = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//   Program-load port of the instruction memory loader.
//   ld_start  host -> loader  pulse: begin a load at ld_base
//   ld_base   host -> loader  first write address, sampled with ld_start
//   ld_valid  host -> loader  ld_data is valid
//   ld_ready  loader -> host  word accepted when ld_valid & ld_ready
//   ld_data   host -> loader  instruction word
//   ld_last   host -> loader  marks the final word of the program
// -----------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);

  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;

  modport master (
    output ld_start, ld_base, ld_valid, ld_data, ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_start, ld_base, ld_valid, ld_data, ld_last,
    output ld_ready
  );

endinterface

// File: rtl/imem_loader_ram.sv
// -----------------------------------------------------------------------------
// imem_loader_ram
//   DEPTH x DATA_W instruction storage: one synchronous write port, one
//   asynchronous read port (the single-cycle CPU needs its instruction in the
//   same cycle the pc is presented).
//   clk      clock, rising edge
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  mem[raddr_i], combinational
// -----------------------------------------------------------------------------
module imem_loader_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch on purpose: a loaded program must
  // survive a reset, and a reset loop over every word would forbid RAM mapping.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Instruction memory with a streaming program-load port and run/halt
//   sequencing for the single-cycle 16-bit CPU.
//   IDLE -> LOAD (ld_start) -> BOOT (accepted ld_last) -> RUN (1 cycle later)
//   -> HALTED (HALT opcode fetched) -> LOAD (ld_start) ...
//   clk        clock, rising edge
//   reset      asynchronous, active-low reset
//   ld_if      program-load port (slave side)
//   pc         CPU fetch address
//   instr      mem[pc] in RUN, 0 otherwise
//   cpu_reset  active-high reset to the CPU; low only in RUN
//   halted     high in HALTED
//   cycle_cnt  CPU cycles executed in the current/last run
//   ld_count   words accepted in the current/last load (saturates at DEPTH)
//   err_ovf    sticky: more than DEPTH words offered in one load
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 8,
  parameter int                OP_W    = 5,
  parameter logic [OP_W-1:0]   HALT_OP = OP_HALT,
  parameter int                CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  imem_loader_if.slave      ld_if,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic              cpu_reset,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [ADDR_W:0]   ld_count,
  output logic              err_ovf
);

  // ld_count value meaning "memory completely filled by this load"
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]        state_q,     state_d;
  logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [ADDR_W:0]   ld_count_q,  ld_count_d;
  logic              err_ovf_q,   err_ovf_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;

  logic [DATA_W-1:0] rd_data;
  logic              accept;
  logic              mem_full;
  logic              wr_en;
  logic              halt_hit;

  assign ld_if.ld_ready = (state_q == ST_LOAD);
  assign accept         = ld_if.ld_valid & ld_if.ld_ready;
  assign mem_full       = (ld_count_q == DEPTH_CNT);
  // Once DEPTH words are in, extra words are still handshaken (so the host
  // can reach ld_last) but never written, protecting the start of the program.
  assign wr_en          = accept & ~mem_full;
  assign halt_hit       = (state_q == ST_RUN) &&
                          (rd_data[DATA_W-1 -: OP_W] == HALT_OP);

  imem_loader_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (ld_if.ld_data),
    .raddr_i (pc),
    .rdata_o (rd_data)
  );

  // NOTE: every next-state variable gets its hold value first, so no path
  // through the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    ld_count_d  = ld_count_q;
    err_ovf_d   = err_ovf_q;
    cycle_cnt_d = cycle_cnt_q;

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (ld_if.ld_start) begin
          state_d    = ST_LOAD;
          wr_ptr_d   = ld_if.ld_base;
          ld_count_d = '0;
          err_ovf_d  = 1'b0;
        end
      end

      ST_LOAD: begin
        if (accept) begin
          if (mem_full) begin
            err_ovf_d = 1'b1;
          end else begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            ld_count_d = ld_count_q + 1'b1;
          end
          if (ld_if.ld_last) begin
            state_d = ST_BOOT;
          end
        end
      end

      // One cycle with cpu_reset high and the new program already in memory.
      ST_BOOT: begin
        cycle_cnt_d = '0;
        state_d     = ST_RUN;
      end

      // The HALT cycle itself is counted; HALTED then freezes the counter.
      ST_RUN: begin
        cycle_cnt_d = cycle_cnt_q + 1'b1;
        if (halt_hit) begin
          state_d = ST_HALTED;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      ld_count_q  <= '0;
      err_ovf_q   <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      ld_count_q  <= ld_count_d;
      err_ovf_q   <= err_ovf_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign instr     = (state_q == ST_RUN) ? rd_data : '0;
  assign cpu_reset = (state_q != ST_RUN);
  assign halted    = (state_q == ST_HALTED);
  assign cycle_cnt = cycle_cnt_q;
  assign ld_count  = ld_count_q;
  assign err_ovf   = err_ovf_q;

endmodule
